// File: rtl/isp_frame_sequencer.sv
// Feeds one Bayer RAW frame into the ISP pipeline. It issues the newFrame pulse and waits
// out the settle time, then streams blanked rows and emits zero-data flush rows until done.
module isp_frame_sequencer #(
  parameter int unsigned width        = 320,
  parameter int unsigned height       = 240,
  parameter int unsigned settleCycles = 32,
  parameter int unsigned hBlank       = 16,
  parameter int unsigned flushRowsMax = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         iStart,
  input  logic                         iSrcValid,
  input  logic [7:0]                   iSrcData,
  output logic                         oSrcReady,
  output logic                         oNewFrame,
  output logic                         oValid,
  output logic [7:0]                   oData,
  input  logic                         iDone,
  output logic                         oBusy,
  output logic                         oFrameDone,
  output logic                         oTimeout,
  output logic [$clog2(height+1)-1:0]  oRow,
  output logic [$clog2(width+1)-1:0]   oCol
);
  localparam int unsigned RowW   = $clog2(height + 1);
  localparam int unsigned ColW   = $clog2(width + 1);
  localparam int unsigned FlRaw  = $clog2(flushRowsMax + 1);
  localparam int unsigned FlW    = (FlRaw > 0) ? FlRaw : 1;
  localparam int unsigned MaxSh  = (settleCycles > hBlank) ? settleCycles : hBlank;
  localparam int unsigned CntMax = (width > MaxSh) ? width : MaxSh;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    StIdle, StStart, StSettle, StActive, StHblank, StFlush, StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [FlW-1:0]  flush_cnt_q, flush_cnt_d;
  logic [RowW-1:0] row_q, row_d;
  logic [ColW-1:0] col_q, col_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;
  logic            timeout_q, timeout_d;
  logic            in_flush_q, in_flush_d;

  logic accept, col_last, row_last, cnt_last, done_now, flush_full, start_go, flush_end;

  assign accept     = (state_q == StActive) && iSrcValid;
  assign col_last   = (col_q == ColW'(width - 1));
  assign row_last   = (row_q == RowW'(height - 1));
  assign done_now   = done_q || iDone;
  assign flush_full = (flush_cnt_q == FlW'(flushRowsMax));
  assign start_go   = (state_q == StIdle) && iStart;
  assign flush_end  = (state_q == StFlush) && cnt_last;

  always_comb begin
    cnt_last = 1'b0;
    case (state_q)
      StSettle: cnt_last = (cnt_q == CntW'(settleCycles - 1));
      StHblank: cnt_last = (cnt_q == CntW'(hBlank - 1));
      StFlush:  cnt_last = (cnt_q == CntW'(width - 1));
      default:  cnt_last = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (iStart) state_d = StStart;
      StStart:  state_d = StSettle;
      StSettle: if (cnt_last) state_d = StActive;
      StActive: if (accept && col_last) state_d = StHblank;
      StHblank: if (cnt_last) state_d = (in_flush_q || row_last) ? StFlush : StActive;
      StFlush: begin
        // Done is only looked at here so a flush row is never cut short.
        if (cnt_last) begin
          if (done_now)        state_d = StDone;
          else if (flush_full) state_d = StIdle;
          else                 state_d = StHblank;
        end
      end
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    oSrcReady  = (state_q == StActive);
    oNewFrame  = (state_q == StStart);
    oFrameDone = (state_q == StDone);
    oBusy      = (state_q != StIdle);
  end

  always_comb begin
    cnt_d = '0;
    if ((state_q inside {StSettle, StHblank, StFlush}) && !cnt_last) cnt_d = cnt_q + CntW'(1);

    col_d = col_q;
    if (start_go)    col_d = '0;
    else if (accept) col_d = col_last ? '0 : col_q + ColW'(1);

    row_d = row_q;
    if (start_go) row_d = '0;
    else if ((state_q == StHblank) && cnt_last && !in_flush_q && !row_last)
      row_d = row_q + RowW'(1);

    in_flush_d = in_flush_q;
    if (start_go)                  in_flush_d = 1'b0;
    else if (state_q == StFlush)   in_flush_d = 1'b1;

    flush_cnt_d = flush_cnt_q;
    if (start_go) flush_cnt_d = '0;
    else if (flush_end && !done_now && !flush_full) flush_cnt_d = flush_cnt_q + FlW'(1);

    done_d = done_q;
    if (start_go) done_d = 1'b0;
    else if (iDone && (state_q inside {StStart, StSettle, StActive, StHblank, StFlush}))
      done_d = 1'b1;

    timeout_d = timeout_q;
    if (start_go) timeout_d = 1'b0;
    else if (flush_end && !done_now && flush_full) timeout_d = 1'b1;

    valid_d = accept || (state_q == StFlush);
    data_d  = data_q;
    if (accept)                  data_d = iSrcData;
    else if (state_q == StFlush) data_d = 8'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      in_flush_q  <= 1'b0;
      flush_cnt_q <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= 8'd0;
    end else begin
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      in_flush_q  <= in_flush_d;
      flush_cnt_q <= flush_cnt_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
    end
  end

  assign oValid   = valid_q;
  assign oData    = data_q;
  assign oTimeout = timeout_q;
  assign oRow     = row_q;
  assign oCol     = col_q;

endmodule

// File: doc/isp_frame_sequencer.md
Name: isp_frame_sequencer

Overview:
Sequences one frame of Bayer RAW pixels into the processing pipeline (demosaic -> filter -> rgb2ycc -> ycc2rgb).
- Issues the newFrame pulse and waits a settle period.
- Streams width x height pixels from a valid/ready source, inserting horizontal blanking between rows.
- After the last input row, keeps the pipeline moving with zero-data flush rows until the pipeline reports done.
- Replaces the hand-written stimulus sequencing used in simulation and is the block the top level instantiates in front of processing.

Parameters:
width, 320, pixels per row
height, 240, rows per frame
settleCycles, 32, idle cycles after oNewFrame before the first pixel
hBlank, 16, oValid-low cycles after every row (input and flush rows)
flushRowsMax, 8, flush rows without iDone before timeout

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
iStart  in  1  start one frame; sampled only in IDLE
iSrcValid  in  1  source pixel valid
iSrcData  in  8  source RAW pixel
oSrcReady  out  1  sequencer accepts the source pixel this cycle
oNewFrame  out  1  one-cycle frame-start pulse to the pipeline
oValid  out  1  pixel valid to the pipeline (iValid of processing)
oData  out  8  pixel to the pipeline (iData of processing)
iDone  in  1  pipeline done indication (oDoneDemosaic); may be a pulse
oBusy  out  1  high in every state except IDLE
oFrameDone  out  1  one-cycle pulse on successful completion
oTimeout  out  1  sticky; set on flush timeout, cleared by the next accepted iStart
oRow  out  $clog2(height+1)  current input row
oCol  out  $clog2(width+1)  current column

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - oNewFrame, oValid, oFrameDone, oTimeout, oBusy and oSrcReady are 0; oData, oRow, oCol are 0.
  - Reset asserted mid-frame aborts immediately; no oFrameDone is produced.
- States: IDLE, START, SETTLE, ACTIVE, HBLANK, FLUSH, DONE.
- IDLE:
  - iStart=1 -> START. Clear the done latch, oRow, oCol and oTimeout.
  - iStart in any other state is ignored.
- START: exactly 1 cycle with oNewFrame=1, then -> SETTLE.
- SETTLE: settleCycles cycles with oValid=0, then -> ACTIVE.
- ACTIVE:
  - oSrcReady=1 (combinational from state only; no dependence on iSrcValid).
  - On each cycle with iSrcValid&&oSrcReady, next cycle oValid=1 and oData=iSrcData. Otherwise next cycle oValid=0 and oData holds its value. Latency is 1 cycle.
  - A source stall mid-row produces an oValid gap; oCol does not advance.
  - oCol increments per accepted pixel. On accepting column width-1: oCol<=0, oSrcReady drops in the following cycle, -> HBLANK.
- HBLANK:
  - hBlank cycles with oValid=0 and oSrcReady=0.
  - Exit after an input row: if oRow==height-1, go to FLUSH with oRow held. Otherwise oRow++ and go to ACTIVE.
  - Exit after a flush row: go to FLUSH.
- FLUSH:
  - width consecutive cycles with oValid=1, oData=0, oSrcReady=0. Flush output is registered, consistent with ACTIVE.
  - After the width-th cycle:
    - Done latch set -> DONE.
    - Else if flush-row count == flushRowsMax -> set oTimeout and go to IDLE (no oFrameDone).
    - Else flush count++ and go to HBLANK.
- Done latch: set by iDone=1 in any cycle from START through FLUSH. Evaluated only at flush-row end, so a full flush row always completes. iDone during ACTIVE is latched, and at least one flush row is still emitted.
- DONE: oFrameDone=1 for 1 cycle, -> IDLE.
- Counters:
  - oCol wraps width-1 -> 0. oRow never exceeds height-1.
  - Flush count is $clog2(flushRowsMax+1) bits and saturates.
- Simultaneous events:
  - iDone on the last flush cycle counts for that row end.
  - An iStart arriving in the same cycle as the DONE->IDLE transition is ignored; a new start needs iStart in IDLE.

Test Plan:
- Reset mid-ACTIVE (width=4, height=2, settleCycles=2, hBlank=2): assert reset=0 on the 3rd pixel -> all outputs 0 the same cycle, state IDLE, no oFrameDone.
- Nominal frame (width=4, height=2, settleCycles=2, hBlank=2), source always valid with data 1..8, iDone pulsed during the 1st flush row:
  - oNewFrame 1 cycle, then 2 idle cycles.
  - oValid carries 1,2,3,4, then 2 low cycles, then 5,6,7,8, then 2 low cycles.
  - Then 4 cycles of oValid=1 with oData=0, then oFrameDone pulse; oBusy falls.
- Source stall: iSrcValid=0 for 3 cycles after pixel 2 -> 3-cycle oValid gap, oCol holds at 2, output order unchanged, total pixels 8.
- Late done: iDone asserted during the 3rd flush row -> exactly 3 flush rows of 4 zero pixels, each followed by 2 blank cycles except the last, then oFrameDone.
- Timeout (flushRowsMax=2), iDone never asserted -> 3 flush rows, oTimeout=1, IDLE, no oFrameDone; next iStart clears oTimeout.
- iStart held high through the whole frame -> exactly one oNewFrame per frame. A second frame starts only via iStart seen in IDLE after oFrameDone.
